data_mem_arbiter: RTL and testbench

Two-port arbiter and sequencer in front of the single-port `data_memory` (256 × 32-bit words, combinational read, write on `posedge clk`).
- Shares the memory between the CPU load/store path (port 0) and the test/DMA loader (port 1).
- Arbitration is round-robin with bounded burst ownership.
- Rejects misaligned and out-of-range accesses.
- Returns registered read data with a one-cycle response pulse.

---
 rtl/data_mem_arb_pkg.sv | 25 ++
 rtl/data_mem_arbiter_if.sv | 33 +++
 rtl/data_memory.sv | 41 ++++
 rtl/dmem_addr_check.sv | 24 ++
 rtl/data_mem_arbiter.sv | 175 +++++++++++++++++
 tb/tb_data_mem_arbiter.sv | 257 +++++++++++++++++++++++++
 6 files changed

// File: rtl/data_mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// data_mem_arb_pkg
// Shared definitions for the two-port data-memory arbiter.
//   arb_state_e         : arbiter ownership state (IDLE / OWN0 / OWN1).
//   WORD_LSB            : number of byte-offset bits in a word address.
//   DEFAULT_DEPTH_WORDS : default memory depth in 32-bit words.
//   DEFAULT_MAX_BURST   : default consecutive-grant limit under contention.
//   BURST_W             : width of the burst counter (holds up to 15).
// -----------------------------------------------------------------------------
package data_mem_arb_pkg;

  // The 2-bit encoding leaves 2'b11 unused; the arbiter treats it as illegal
  // and returns to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  localparam int WORD_LSB            = 2;
  localparam int DEFAULT_DEPTH_WORDS = 256;
  localparam int DEFAULT_MAX_BURST   = 4;
  localparam int BURST_W             = 4;

endpackage

// File: rtl/data_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// data_mem_arbiter_if
// Request/response bundle for one port of the data-memory arbiter.
//   req, we, addr, wdata : request side.
//                          The requester holds them stable until gnt.
//   gnt                  : combinational grant; the access happens this cycle.
//   rvalid, rdata, err   : registered one-cycle response.
// Modports:
//   master : the requester (CPU load/store path or DMA loader).
//   slave  : the arbiter.
// -----------------------------------------------------------------------------
interface data_mem_arbiter_if;

  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata, err
  );

endinterface

// File: rtl/data_memory.sv
// -----------------------------------------------------------------------------
// data_memory
// Single-port word memory: combinational read, write on the rising clock edge.
//   clk            : clock.
//   mem_write      : write enable for this cycle.
//   mem_address    : byte address; only the word-index bits are used.
//   mem_write_data : data stored at the rising edge when mem_write is high.
//   mem_read_data  : combinational read of the addressed word.
// -----------------------------------------------------------------------------
module data_memory #(
  parameter int DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        mem_write,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_write_data,
  output logic [31:0] mem_read_data
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-1:0] word_idx;
  logic          unused_addr_bits;

  // Out-of-range addresses are filtered upstream.
  // The truncated upper bits and the byte offset are deliberately ignored.
  assign word_idx         = mem_address[AW+1:2];
  assign unused_addr_bits = ^{mem_address[31:AW+2], mem_address[1:0]};

  // NOTE: the storage array has no reset. Clearing a RAM would cost a
  // per-word write path, and its contents are defined by the loader anyway.
  always_ff @(posedge clk) begin
    if (mem_write) begin
      mem[word_idx] <= mem_write_data;
    end
  end

  assign mem_read_data = mem[word_idx];

endmodule

// File: rtl/dmem_addr_check.sv
// -----------------------------------------------------------------------------
// dmem_addr_check
// Combinational legality check for a byte address into the data memory.
//   addr    : byte address from a requesting port.
//   illegal : 1 when the address is not word aligned or lies past the last
//             word (word index >= DEPTH_WORDS).
// -----------------------------------------------------------------------------
module dmem_addr_check
  import data_mem_arb_pkg::*;
#(
  parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS
) (
  input  logic [31:0] addr,
  output logic        illegal
);

  logic misaligned;
  logic out_of_range;

  assign misaligned   = (addr[WORD_LSB-1:0] != '0);
  assign out_of_range = (32'(addr[31:WORD_LSB]) >= 32'(DEPTH_WORDS));
  assign illegal      = misaligned | out_of_range;

endmodule

// File: rtl/data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// data_mem_arbiter
// Shares one single-port data memory between port 0 (CPU load/store) and
// port 1 (test/DMA loader). Arbitration is round-robin, and an owner may keep
// at most MAX_BURST consecutive grants while the other port waits.
// Misaligned and out-of-range accesses are still granted, but they never
// touch memory and respond with err=1. Every grant produces a registered
// response pulse one cycle later.
//   clk, rst_n      : clock and asynchronous active-low reset.
//   p0, p1          : port bundles (slave side).
//   mem_write       : write enable to memory; gated by reset and legality.
//   mem_address     : byte address of the granted port, 0 when idle.
//   mem_write_data  : write data of the granted port, 0 when idle.
//   mem_read_data   : combinational read data from memory.
// -----------------------------------------------------------------------------
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int MAX_BURST   = DEFAULT_MAX_BURST
) (
  input  logic                clk,
  input  logic                rst_n,
  data_mem_arbiter_if.slave   p0,
  data_mem_arbiter_if.slave   p1,
  output logic                mem_write,
  output logic [31:0]         mem_address,
  output logic [31:0]         mem_write_data,
  input  logic [31:0]         mem_read_data
);

  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);
  localparam logic [BURST_W-1:0] BURST_ONE = BURST_W'(1);

  arb_state_e         state_q, state_d;
  logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
  logic               last_port_q, last_port_d;

  logic               rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic [31:0]        rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic               err0_q, err0_d, err1_q, err1_d;

  logic               illegal0, illegal1;
  logic               grant0, grant1;   // arbitration result before reset gating
  logic               gnt0, gnt1;

  dmem_addr_check #(.DEPTH_WORDS(DEPTH_WORDS)) u_chk0 (
    .addr    (p0.addr),
    .illegal (illegal0)
  );

  dmem_addr_check #(.DEPTH_WORDS(DEPTH_WORDS)) u_chk1 (
    .addr    (p1.addr),
    .illegal (illegal1)
  );

  // Arbitration and next-state logic.
  // NOTE: every variable gets a default at the top of the always_comb, so no
  // path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    last_port_d = last_port_q;
    grant0      = 1'b0;
    grant1      = 1'b0;

    case (state_q)
      IDLE: begin
        // Under contention, the port that was not served last wins.
        if (p0.req && (!p1.req || last_port_q)) grant0 = 1'b1;
        else if (p1.req)                        grant1 = 1'b1;
      end
      OWN0: begin
        if (p0.req && (burst_cnt_q < BURST_MAX || !p1.req)) grant0 = 1'b1;
        else if (p1.req)                                    grant1 = 1'b1;
      end
      OWN1: begin
        if (p1.req && (burst_cnt_q < BURST_MAX || !p0.req)) grant1 = 1'b1;
        else if (p0.req)                                    grant0 = 1'b1;
      end
      default: ;  // illegal encoding: no grant; falls through to IDLE below
    endcase

    // A re-grant to the current owner extends its burst; a grant to a new
    // owner starts a fresh burst of one.
    if (grant0) begin
      state_d     = OWN0;
      last_port_d = 1'b0;
      if (state_q != OWN0)              burst_cnt_d = BURST_ONE;
      else if (burst_cnt_q < BURST_MAX) burst_cnt_d = burst_cnt_q + BURST_ONE;
    end else if (grant1) begin
      state_d     = OWN1;
      last_port_d = 1'b1;
      if (state_q != OWN1)              burst_cnt_d = BURST_ONE;
      else if (burst_cnt_q < BURST_MAX) burst_cnt_d = burst_cnt_q + BURST_ONE;
    end else begin
      state_d     = IDLE;
      burst_cnt_d = '0;
    end
  end

  // While reset is held, requests must not produce grants or memory writes.
  assign gnt0   = grant0 & rst_n;
  assign gnt1   = grant1 & rst_n;
  assign p0.gnt = gnt0;
  assign p1.gnt = gnt1;

  always_comb begin
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    if (gnt0) begin
      mem_address    = p0.addr;
      mem_write_data = p0.wdata;
      mem_write      = p0.we & ~illegal0;
    end else if (gnt1) begin
      mem_address    = p1.addr;
      mem_write_data = p1.wdata;
      mem_write      = p1.we & ~illegal1;
    end
  end

  // Response capture: rdata/err hold until that port is granted again.
  // Writes and illegal accesses return zero data.
  always_comb begin
    rvalid0_d = gnt0;
    rvalid1_d = gnt1;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    err0_d    = err0_q;
    err1_d    = err1_q;
    if (gnt0) begin
      err0_d   = illegal0;
      rdata0_d = (!illegal0 && !p0.we) ? mem_read_data : '0;
    end
    if (gnt1) begin
      err1_d   = illegal1;
      rdata1_d = (!illegal1 && !p1.we) ? mem_read_data : '0;
    end
  end

  // NOTE: non-blocking assignments make every flop sample its _d value from
  // before the edge, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      burst_cnt_q <= '0;
      last_port_q <= 1'b1;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      err0_q      <= 1'b0;
      err1_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      last_port_q <= last_port_d;
      rvalid0_q   <= rvalid0_d;
      rvalid1_q   <= rvalid1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      err0_q      <= err0_d;
      err1_q      <= err1_d;
    end
  end

  assign p0.rvalid = rvalid0_q;
  assign p1.rvalid = rvalid1_q;
  assign p0.rdata  = rdata0_q;
  assign p1.rdata  = rdata1_q;
  assign p0.err    = err0_q;
  assign p1.err    = err1_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_data_mem_arbiter
// Drives data_mem_arbiter in front of data_memory with directed vectors.
// A reference model of the arbitration rules and the memory contents is
// checked against the DUT on every falling clock edge. Hand-computed literal
// expectations in the stimulus thread pin the model itself.
// -----------------------------------------------------------------------------
module tb_data_mem_arbiter;
  import data_mem_arb_pkg::*;

  localparam int DEPTH = 256;
  localparam int MAXB  = 4;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        mem_write;
  logic [31:0] mem_address, mem_write_data, mem_read_data;

  data_mem_arbiter_if bus0 ();
  data_mem_arbiter_if bus1 ();

  data_mem_arbiter #(.DEPTH_WORDS(DEPTH), .MAX_BURST(MAXB)) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .p0             (bus0),
    .p1             (bus1),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  data_memory #(.DEPTH_WORDS(DEPTH)) u_mem (
    .clk            (clk),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: who may be served this cycle, what memory holds, and
  // what each port must see one cycle after its grant.
  // ---------------------------------------------------------------------------
  logic [31:0] m_mem [DEPTH];
  int          m_owner = -1;   // port served last cycle, -1 when none
  int          m_run   = 0;    // consecutive grants to m_owner
  int          m_last  = 1;    // port served most recently
  logic        e_rv  [2] = '{1'b0, 1'b0};
  logic [31:0] e_rd  [2] = '{32'd0, 32'd0};
  logic        e_err [2] = '{1'b0, 1'b0};

  always @(negedge clk) begin : ref_model
    logic        rq [2];
    logic        wr [2];
    logic [31:0] ad [2];
    logic [31:0] wd [2];
    int          g;
    bit          ok;
    logic [31:0] a, d;

    if (!rst_n) begin
      check("rst_gnt",    {30'd0, bus1.gnt, bus0.gnt}, 32'd0);
      check("rst_rvalid", {30'd0, bus1.rvalid, bus0.rvalid}, 32'd0);
      check("rst_err",    {30'd0, bus1.err, bus0.err}, 32'd0);
      check("rst_rdata0", bus0.rdata, 32'd0);
      check("rst_rdata1", bus1.rdata, 32'd0);
      check("rst_mem_write", 32'(mem_write), 32'd0);
      check("rst_mem_address", mem_address, 32'd0);
      check("rst_mem_wdata", mem_write_data, 32'd0);
      m_owner = -1;
      m_run   = 0;
      m_last  = 1;
      e_rv    = '{1'b0, 1'b0};
      e_rd    = '{32'd0, 32'd0};
      e_err   = '{1'b0, 1'b0};
    end else begin
      // Responses to last cycle's grant.
      check("rvalid0", 32'(bus0.rvalid), 32'(e_rv[0]));
      check("rvalid1", 32'(bus1.rvalid), 32'(e_rv[1]));
      check("rdata0",  bus0.rdata, e_rd[0]);
      check("rdata1",  bus1.rdata, e_rd[1]);
      check("err0",    32'(bus0.err), 32'(e_err[0]));
      check("err1",    32'(bus1.err), 32'(e_err[1]));

      rq[0] = bus0.req;   rq[1] = bus1.req;
      wr[0] = bus0.we;    wr[1] = bus1.we;
      ad[0] = bus0.addr;  ad[1] = bus1.addr;
      wd[0] = bus0.wdata; wd[1] = bus1.wdata;

      // The owner keeps the memory until its run is used up while the other
      // port waits; otherwise whoever asks is served, alternating on ties.
      g = -1;
      if (m_owner >= 0 && rq[m_owner] && (m_run < MAXB || !rq[1 - m_owner])) g = m_owner;
      else if (rq[0] && rq[1]) g = 1 - m_last;
      else if (rq[0])          g = 0;
      else if (rq[1])          g = 1;

      if (g < 0)             m_run = 0;
      else if (g == m_owner) m_run = m_run + 1;
      else                   m_run = 1;
      m_owner = g;
      if (g >= 0) m_last = g;

      check("gnt0", 32'(bus0.gnt), 32'(g == 0));
      check("gnt1", 32'(bus1.gnt), 32'(g == 1));

      a  = (g >= 0) ? ad[g] : 32'd0;
      d  = (g >= 0) ? wd[g] : 32'd0;
      ok = (g >= 0) && (a % 4 == 0) && (a / 4 < DEPTH);
      check("mem_address",    mem_address, a);
      check("mem_write_data", mem_write_data, d);
      check("mem_write",      32'(mem_write), 32'(ok && wr[g]));

      e_rv[0] = (g == 0);
      e_rv[1] = (g == 1);
      if (g >= 0) begin
        e_err[g] = !ok;
        e_rd[g]  = (ok && !wr[g]) ? m_mem[a / 4] : 32'd0;
        if (ok && wr[g]) m_mem[a / 4] = d;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus: inputs change 2 time units after a rising edge; the literal
  // checks sample 1 unit later, once the combinational outputs have settled.
  // ---------------------------------------------------------------------------
  task automatic drive(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                       input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
    @(posedge clk);
    #2;
    bus0.req = r0; bus0.we = w0; bus0.addr = a0; bus0.wdata = d0;
    bus1.req = r1; bus1.we = w1; bus1.addr = a1; bus1.wdata = d1;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  logic [11:0] contest_pat0;

  initial begin
    bus0.req = 1'b0; bus0.we = 1'b0; bus0.addr = '0; bus0.wdata = '0;
    bus1.req = 1'b0; bus1.we = 1'b0; bus1.addr = '0; bus1.wdata = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Loader (port 1) preloads words 0..3 with 5, 10, 15, 0.
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 32'h0, 32'd5);
    check("preload_gnt1", 32'(bus1.gnt), 32'd1);
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 32'h4, 32'd10);
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 32'h8, 32'd15);
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 32'hC, 32'd0);
    idle();

    // Port 0 reads 0x4: same-cycle grant, one-cycle response.
    drive(1'b1, 1'b0, 32'h4, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    check("t1_gnt0", 32'(bus0.gnt), 32'd1);
    idle();
    check("t1_rvalid0", 32'(bus0.rvalid), 32'd1);
    check("t1_rdata0",  bus0.rdata, 32'd10);
    check("t1_err0",    32'(bus0.err), 32'd0);
    idle();
    check("t1_pulse_once", 32'(bus0.rvalid), 32'd0);
    check("t1_rdata_hold", bus0.rdata, 32'd10);

    // Port 1 writes 0x8, then port 0 reads it back the next cycle.
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 32'h8, 32'hDEAD_BEEF);
    check("t2_mem_write", 32'(mem_write), 32'd1);
    drive(1'b1, 1'b0, 32'h8, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    check("t2_wr_rvalid1", 32'(bus1.rvalid), 32'd1);
    check("t2_wr_rdata1",  bus1.rdata, 32'd0);
    idle();
    check("t2_raw_rdata0", bus0.rdata, 32'hDEAD_BEEF);

    // Illegal accesses on port 1: misaligned read, out-of-range read and write.
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'h6, 32'd0);
    check("t4_gnt1_misaligned", 32'(bus1.gnt), 32'd1);
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'h400, 32'd0);
    check("t4_err1_misaligned",   32'(bus1.err), 32'd1);
    check("t4_rdata1_misaligned", bus1.rdata, 32'd0);
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 32'h400, 32'hFFFF_FFFF);
    check("t4_no_mem_write", 32'(mem_write), 32'd0);
    check("t4_err1_range",   32'(bus1.err), 32'd1);
    idle();
    check("t4_rvalid1_write", 32'(bus1.rvalid), 32'd1);
    check("t4_err1_write",    32'(bus1.err), 32'd1);

    // Contention on word 0: four grants each, port 0 first (port 1 served last).
    contest_pat0 = 12'b1111_0000_1111;
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 1'b0, 32'h0, 32'd0, 1'b1, 1'b0, 32'h0, 32'd0);
      check($sformatf("t3_gnt0_%0d", i), 32'(bus0.gnt), 32'(contest_pat0[i]));
      check($sformatf("t3_gnt1_%0d", i), 32'(bus1.gnt), 32'(!contest_pat0[i]));
      if (i > 0) begin
        check($sformatf("t3_one_rvalid_%0d", i), 32'(bus0.rvalid) + 32'(bus1.rvalid), 32'd1);
        check($sformatf("t3_rdata_%0d", i), bus0.rvalid ? bus0.rdata : bus1.rdata, 32'd5);
      end
    end
    idle();
    check("t3_last_rdata1", bus1.rdata, 32'd5);

    // Owner drops its request while the other asks: handover in the same cycle.
    drive(1'b1, 1'b0, 32'h4, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'h8, 32'd0);
    check("t6_gnt1_handover", 32'(bus1.gnt), 32'd1);
    check("t6_gnt0_dropped",  32'(bus0.gnt), 32'd0);
    idle();
    check("t6_state_own1", 32'(u_dut.state_q), 32'(OWN1));
    check("t6_burst_cnt",  32'(u_dut.burst_cnt_q), 32'd1);

    // Make port 0 the last served, then hit reset with a port 0 write pending.
    drive(1'b1, 1'b0, 32'h0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clk);
    #2;
    bus0.req = 1'b1; bus0.we = 1'b1; bus0.addr = 32'hC; bus0.wdata = 32'h1234_5678;
    rst_n = 1'b0;
    #1;
    check("t5_rst_gnt0",      32'(bus0.gnt), 32'd0);
    check("t5_rst_mem_write", 32'(mem_write), 32'd0);
    check("t5_rst_rvalid0",   32'(bus0.rvalid), 32'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    bus0.req = 1'b1; bus0.we = 1'b0; bus0.addr = 32'hC; bus0.wdata = 32'd0;
    bus1.req = 1'b1; bus1.we = 1'b0; bus1.addr = 32'h0; bus1.wdata = 32'd0;
    #1;
    check("t5_first_gnt0", 32'(bus0.gnt), 32'd1);
    check("t5_first_gnt1", 32'(bus1.gnt), 32'd0);
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'h0, 32'd0);
    check("t5_rvalid0",     32'(bus0.rvalid), 32'd1);
    check("t5_word3_clean", bus0.rdata, 32'd0);
    idle();
    check("t5_rdata1", bus1.rdata, 32'd5);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
